reg_file_param: RTL and testbench

Parametrised register file that sits between the instruction decoder and the ALU / load-store unit. It generalises the fixed 16-bit register file with configurable data width, register count and immediate width. It adds a one-outstanding-load scoreboard with a hazard stall, same-cycle write-to-read bypass, and a double-width ALU write-back. All outputs toward the ALU and store path are registered.

---
 rtl/reg_file_param.sv | 132 +++++++++++++
 tb/tb_reg_file_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// Parametrised register file with one-outstanding-load scoreboard, same-cycle
// write bypass, double-width ALU write-back and registered ALU/store outputs.
module reg_file_param #(
    parameter int DATA_W = 16,
    parameter int NREG   = 16,
    parameter int AW     = 4,
    parameter int IMM_W  = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [1:0]          func,
    input  logic [3*AW-1:0]     addr,
    input  logic [IMM_W-1:0]    imm_in,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                wb_valid,
    input  logic                wb_wide,
    input  logic [AW-1:0]       wb_addr,
    input  logic [2*DATA_W-1:0] wb_data,
    output logic                busy,
    output logic                ld_pending,
    output logic                alu_valid,
    output logic [DATA_W-1:0]   alu_in1,
    output logic [DATA_W-1:0]   alu_in2,
    output logic                st_valid,
    output logic [DATA_W-1:0]   store_out
);

    localparam logic [1:0] FUNC_ALU = 2'b00;
    localparam logic [1:0] FUNC_IMM = 2'b01;
    localparam logic [1:0] FUNC_LD  = 2'b10;
    localparam logic [1:0] FUNC_ST  = 2'b11;

    logic [DATA_W-1:0] regs [NREG];
    logic [AW-1:0]     pdest;

    logic [AW-1:0]     dest, src1, src2, wb_hi_addr;
    logic [DATA_W-1:0] wb_lo, wb_hi, imm_ext, rd1, rd2;
    logic              eff_pending, accept, ld_ret, wb_hi_en, imm_we;

    // Priority: load return > write-back low half > write-back high half > stored.
    function automatic logic [DATA_W-1:0] bypass_rd(
        input logic [AW-1:0]     idx,
        input logic [DATA_W-1:0] stored
    );
        if (idx == '0)
            return '0;
        else if (ld_ret && pdest == idx)
            return ld_data;
        else if (wb_valid && wb_addr == idx)
            return wb_lo;
        else if (wb_hi_en && wb_hi_addr == idx)
            return wb_hi;
        else
            return stored;
    endfunction

    // Stage p0: decode, hazard check and bypassed reads
    always_comb begin
        dest        = addr[3*AW-1:2*AW];
        src1        = addr[2*AW-1:AW];
        src2        = addr[AW-1:0];
        wb_lo       = wb_data[DATA_W-1:0];
        wb_hi       = wb_data[2*DATA_W-1:DATA_W];
        wb_hi_addr  = wb_addr + AW'(1);
        wb_hi_en    = wb_valid & wb_wide;
        imm_ext     = DATA_W'(imm_in);
        ld_ret      = ld_valid & ld_pending;
        eff_pending = ld_pending & ~ld_valid;
        busy        = en & eff_pending & ((func == FUNC_LD) | (src1 == pdest) |
                      ((func == FUNC_ALU) & (src2 == pdest)) |
                      ((func == FUNC_IMM) & (dest == pdest)));
        accept      = en & ~busy;
        imm_we      = accept & (func == FUNC_IMM);
        rd1         = bypass_rd(src1, regs[src1]);
        rd2         = bypass_rd(src2, regs[src2]);
    end

    // Register array: r0 is never written; immediate wins any same-register collision
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (imm_we && dest == AW'(i))
                    regs[i] <= imm_ext;
                else if (ld_ret && pdest == AW'(i))
                    regs[i] <= ld_data;
                else if (wb_valid && wb_addr == AW'(i))
                    regs[i] <= wb_lo;
                else if (wb_hi_en && wb_hi_addr == AW'(i))
                    regs[i] <= wb_hi;
            end
        end
    end

    // A load issued in the return cycle replaces the one completing
    always_ff @(posedge clk) begin
        if (rst) begin
            ld_pending <= 1'b0;
            pdest      <= '0;
        end else if (accept && func == FUNC_LD) begin
            ld_pending <= 1'b1;
            pdest      <= dest;
        end else if (ld_ret) begin
            ld_pending <= 1'b0;
        end
    end

    // Stage p1: registered operands and store data
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_valid <= 1'b0;
            st_valid  <= 1'b0;
            alu_in1   <= '0;
            alu_in2   <= '0;
            store_out <= '0;
        end else begin
            alu_valid <= accept & (func == FUNC_ALU);
            st_valid  <= accept & (func == FUNC_ST);
            if (accept && func == FUNC_ALU) begin
                alu_in1 <= rd1;
                alu_in2 <= rd2;
            end
            if (accept && func == FUNC_ST)
                store_out <= rd1;
        end
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: stimulus pushes expected ALU/store
// results into a queue, a negedge monitor pops and compares them.
module tb_reg_file_param;

    localparam int DATA_W = 16;
    localparam int NREG   = 16;
    localparam int AW     = 4;
    localparam int IMM_W  = 8;

    logic                clk = 1'b0;
    logic                rst, en, ld_valid, wb_valid, wb_wide;
    logic [1:0]          func;
    logic [3*AW-1:0]     addr;
    logic [IMM_W-1:0]    imm_in;
    logic [DATA_W-1:0]   ld_data;
    logic [AW-1:0]       wb_addr;
    logic [2*DATA_W-1:0] wb_data;
    logic                busy, ld_pending, alu_valid, st_valid;
    logic [DATA_W-1:0]   alu_in1, alu_in2, store_out;

    typedef struct packed {
        logic              is_st;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_file_param #(.DATA_W(DATA_W), .NREG(NREG), .AW(AW), .IMM_W(IMM_W)) dut (
        .clk(clk), .rst(rst), .en(en), .func(func), .addr(addr), .imm_in(imm_in),
        .ld_valid(ld_valid), .ld_data(ld_data), .wb_valid(wb_valid), .wb_wide(wb_wide),
        .wb_addr(wb_addr), .wb_data(wb_data), .busy(busy), .ld_pending(ld_pending),
        .alu_valid(alu_valid), .alu_in1(alu_in1), .alu_in2(alu_in2),
        .st_valid(st_valid), .store_out(store_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (alu_valid || st_valid) begin
            exp_t e;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got alu_valid=%b st_valid=%b, expected none",
                         alu_valid, st_valid);
            end else begin
                e = exp_q.pop_front();
                check("valid_kind", {31'd0, st_valid}, {31'd0, e.is_st});
                if (e.is_st) begin
                    check("store_out", 32'(store_out), 32'(e.a));
                end else begin
                    check("alu_in1", 32'(alu_in1), 32'(e.a));
                    check("alu_in2", 32'(alu_in2), 32'(e.b));
                end
            end
        end
    end

    task automatic idle();
        en = 0; func = 2'b00; addr = '0; imm_in = '0;
        ld_valid = 0; ld_data = '0; wb_valid = 0; wb_wide = 0; wb_addr = '0; wb_data = '0;
    endtask

    task automatic req(input logic [1:0] f, input int d, input int s1, input int s2,
                       input logic [IMM_W-1:0] imm);
        en = 1; func = f; imm_in = imm;
        addr = {AW'(d), AW'(s1), AW'(s2)};
    endtask

    // Wait to the sampling point of the current cycle, then past the next edge.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic check_busy(input string name, input logic req_v);
        @(negedge clk);
        check(name, {31'd0, busy}, {31'd0, req_v});
    endtask

    task automatic push_alu(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        exp_q.push_back('{is_st: 1'b0, a: a, b: b});
    endtask

    task automatic push_st(input logic [DATA_W-1:0] a);
        exp_q.push_back('{is_st: 1'b1, a: a, b: '0});
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst_ld_pending", {31'd0, ld_pending}, 32'd0);
        check("rst_alu_valid", {31'd0, alu_valid}, 32'd0);
        check("rst_store_out", 32'(store_out), 32'd0);

        // Read after reset: all zero
        req(2'b00, 0, 3, 5, 8'h00); push_alu(16'h0000, 16'h0000);
        check_busy("busy_after_rst", 1'b0); step();

        // Immediate load, then read; r0 ignores writes
        req(2'b01, 2, 0, 0, 8'h01); step();
        req(2'b00, 0, 2, 0, 8'h00); push_alu(16'h0001, 16'h0000); step();
        req(2'b01, 0, 0, 0, 8'hFF); step();
        req(2'b00, 0, 0, 2, 8'h00); push_alu(16'h0000, 16'h0001); step();

        // Load to r4, stalled store, release in ld_valid cycle via bypass
        req(2'b10, 4, 0, 0, 8'h00); check_busy("busy_ld_issue", 1'b0); step();
        for (int i = 0; i < 3; i++) begin
            req(2'b11, 0, 4, 0, 8'h00);
            check_busy("busy_hazard", 1'b1);
            check("ld_pending_stall", {31'd0, ld_pending}, 32'd1);
            step();
        end
        req(2'b11, 0, 4, 0, 8'h00); ld_valid = 1; ld_data = 16'hBEEF; push_st(16'hBEEF);
        check_busy("busy_ld_return", 1'b0); step();
        check("ld_pending_clear", {31'd0, ld_pending}, 32'd0);

        // Wide write-back at r15 wraps high half into r0 (dropped); then r6/r7
        wb_valid = 1; wb_wide = 1; wb_addr = 4'd15; wb_data = 32'h1234_5678; step();
        wb_valid = 1; wb_wide = 1; wb_addr = 4'd6;  wb_data = 32'h1234_5678; step();
        req(2'b00, 0, 15, 0, 8'h00); push_alu(16'h5678, 16'h0000); step();
        req(2'b00, 0, 6, 7, 8'h00);  push_alu(16'h5678, 16'h1234); step();

        // Same-cycle bypass of write-back low half, and imm beats write-back
        req(2'b00, 0, 3, 3, 8'h00); wb_valid = 1; wb_addr = 4'd3; wb_data = 32'h0000_AAAA;
        push_alu(16'hAAAA, 16'hAAAA); step();
        req(2'b01, 3, 0, 0, 8'h55); wb_valid = 1; wb_addr = 4'd3; wb_data = 32'h0000_AAAA; step();
        req(2'b00, 0, 3, 2, 8'h00); push_alu(16'h0055, 16'h0001); step();

        // Bypass of write-back high half
        req(2'b00, 0, 9, 8, 8'h00); wb_valid = 1; wb_wide = 1; wb_addr = 4'd8;
        wb_data = 32'hCAFE_BABE; push_alu(16'hCAFE, 16'hBABE); step();

        // Back-to-back loads: second issued in first one's return cycle
        req(2'b10, 10, 0, 0, 8'h00); step();
        req(2'b10, 11, 0, 0, 8'h00); ld_valid = 1; ld_data = 16'h2222;
        check_busy("busy_b2b_load", 1'b0); step();
        check("ld_pending_b2b", {31'd0, ld_pending}, 32'd1);
        ld_valid = 1; ld_data = 16'h3333; step();
        req(2'b00, 0, 10, 11, 8'h00); push_alu(16'h2222, 16'h3333); step();

        // Reset drops outstanding load; later ld_valid ignored
        req(2'b10, 9, 0, 0, 8'h00); step();
        rst = 1; step(); rst = 0;
        check("rst_drop_ld", {31'd0, ld_pending}, 32'd0);
        check("rst_alu_in1", 32'(alu_in1), 32'd0);
        check("rst_alu_in2", 32'(alu_in2), 32'd0);
        check("rst_store_out2", 32'(store_out), 32'd0);
        req(2'b00, 0, 9, 9, 8'h00); ld_valid = 1; ld_data = 16'h1111; push_alu(16'h0000, 16'h0000);
        check_busy("busy_stale_ld", 1'b0); step();
        req(2'b00, 0, 9, 0, 8'h00); push_alu(16'h0000, 16'h0000); step();
        check("ld_pending_final", {31'd0, ld_pending}, 32'd0);

        repeat (3) step();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
